// File: rtl/fma_post_normalizer.sv
// fma_post_normalizer: back end of the FMA datapath. It turns the wide aligned
// sum (sign, biased exponent, 74-bit magnitude, sticky) into a packed IEEE-754
// result. Three stages: leading-one detect, normalize shift, then RNE round and pack.
// The optional status output Flags_o {overflow, underflow, inexact} exists only
// when the macro POSTNORM_FLAGS_EN is defined.
module fma_post_normalizer #(
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23,
    parameter int PARM_BIAS = 127
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic                              Sign_i,
    input  logic signed [PARM_EXP+1:0]        Exp_i,
    input  logic        [3*PARM_MANT+4:0]     Mant_i,
    input  logic                              Sticky_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic        [PARM_EXP+PARM_MANT:0] Result_o
`ifdef POSTNORM_FLAGS_EN
    ,
    output logic        [2:0]                 Flags_o
`endif
);

    localparam int MW      = 3*PARM_MANT + 5;   // sum width
    localparam int TOP     = MW - 1;            // hidden-bit position after normalization
    localparam int P       = 2*PARM_MANT + 1;   // bit whose weight is 2^(Exp-bias)
    localparam int EW      = PARM_EXP + 3;      // working exponent width
    localparam int LW      = $clog2(MW);
    localparam int RW      = PARM_EXP + PARM_MANT + 1;
    localparam int SUB_OFS = TOP - 1 - P;       // subnormal shift = Exp + SUB_OFS
    localparam int EXP_INF = 2*PARM_BIAS + 1;   // all-ones exponent field

    // Index of the most significant set bit (0 when the input is zero).
    function automatic logic [LW-1:0] lead_one(input logic [MW-1:0] m);
        logic [LW-1:0] l;
        l = '0;
        for (int i = 0; i < MW; i++)
            if (m[i]) l = LW'(i);
        return l;
    endfunction

    // Round-to-nearest-even increment; result carries one extra bit for carry-out.
    function automatic logic [PARM_MANT+1:0] round_rne(input logic [PARM_MANT:0] sig,
                                                       input logic g, input logic s);
        return {1'b0, sig} + (PARM_MANT+2)'(g & (s | sig[0]));
    endfunction

    // Pack sign/exponent/fraction, saturating to signed infinity on overflow.
    function automatic logic [RW-1:0] pack_sat(input logic sign,
                                               input logic signed [EW-1:0] e,
                                               input logic [PARM_MANT-1:0] frac);
        if (e >= EW'(EXP_INF))
            return {sign, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};
        return {sign, e[PARM_EXP-1:0], frac};
    endfunction

    logic load_p0, load_p1, load_p2;

    logic                   vld_p0, sign_p0, sticky_p0, zero_p0;
    logic signed [EW-2:0]   exp_p0;
    logic        [MW-1:0]   mant_p0;
    logic        [LW-1:0]   lead_p0;

    logic                   vld_p1, sign_p1, sticky_p1, zero_p1;
    logic signed [EW-1:0]   er_p1;
    logic        [MW-1:0]   norm_p1;

    logic                   vld_p2;
    logic        [RW-1:0]   result_p2;

    // A stage may load when it is empty or its contents move on this edge.
    assign load_p2    = !vld_p2 || out_ready_i;
    assign load_p1    = !vld_p1 || load_p2;
    assign load_p0    = !vld_p0 || load_p1;
    assign in_ready_o = load_p0;

    // ---- stage boundary p0: leading-one detect ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p0    <= 1'b0;
            sign_p0   <= 1'b0;
            exp_p0    <= '0;
            mant_p0   <= '0;
            sticky_p0 <= 1'b0;
            lead_p0   <= '0;
            zero_p0   <= 1'b0;
        end else if (load_p0) begin
            vld_p0 <= in_valid_i;
            if (in_valid_i) begin
                sign_p0   <= Sign_i;
                exp_p0    <= Exp_i;
                mant_p0   <= Mant_i;
                sticky_p0 <= Sticky_i;
                lead_p0   <= lead_one(Mant_i);
                zero_p0   <= (Mant_i == '0);
            end
        end
    end

    logic signed [EW-1:0] er_c, sh_c;
    logic        [EW-1:0] rs_c;
    logic        [MW-1:0] norm_c;
    logic                 lost_c;

    // Normalize: put the leading one at TOP for normals, or at TOP-1+E for subnormals.
    always_comb begin
        er_c   = EW'(exp_p0) + EW'(lead_p0) - EW'(P);
        sh_c   = EW'(exp_p0) + EW'(SUB_OFS);
        rs_c   = '0;
        norm_c = mant_p0;
        lost_c = 1'b0;
        if (er_c > 0) begin
            norm_c = mant_p0 << (LW'(TOP) - lead_p0);
        end else if (sh_c >= 0) begin
            norm_c = mant_p0 << sh_c;
        end else begin
            rs_c   = (-sh_c > EW'(MW)) ? EW'(MW) : -sh_c;
            norm_c = mant_p0 >> rs_c;
            lost_c = |(mant_p0 & ~({MW{1'b1}} << rs_c));
        end
    end

    // ---- stage boundary p1: normalized magnitude and adjusted exponent ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1    <= 1'b0;
            sign_p1   <= 1'b0;
            zero_p1   <= 1'b0;
            er_p1     <= '0;
            norm_p1   <= '0;
            sticky_p1 <= 1'b0;
        end else if (load_p1) begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                sign_p1   <= sign_p0;
                zero_p1   <= zero_p0;
                er_p1     <= (er_c > 0) ? er_c : '0;
                norm_p1   <= norm_c;
                sticky_p1 <= sticky_p0 | lost_c;
            end
        end
    end

    logic        [PARM_MANT:0]   sig_c;
    logic                        g_c, sa_c;
    logic        [PARM_MANT+1:0] rnd_c;
    logic signed [EW-1:0]        efin_c;
    logic        [RW-1:0]        res_c;

    // Round to nearest even; a carry out of the significand (or a subnormal
    // rounding into the hidden bit) bumps the exponent by one.
    always_comb begin
        sig_c  = norm_p1[TOP -: PARM_MANT+1];
        g_c    = norm_p1[TOP-PARM_MANT-1];
        sa_c   = (|norm_p1[TOP-PARM_MANT-2:0]) | sticky_p1;
        rnd_c  = round_rne(sig_c, g_c, sa_c);
        efin_c = er_p1 + EW'(rnd_c[PARM_MANT+1] | (rnd_c[PARM_MANT] & ~sig_c[PARM_MANT]));
        res_c  = zero_p1 ? '0 : pack_sat(sign_p1, efin_c, rnd_c[PARM_MANT-1:0]);
    end

    // ---- stage boundary p2: packed result, held while the consumer stalls ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p2    <= 1'b0;
            result_p2 <= '0;
        end else if (load_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1)
                result_p2 <= res_c;
        end
    end

    assign out_valid_o = vld_p2;
    assign Result_o    = result_p2;

`ifdef POSTNORM_FLAGS_EN
    logic       ovf_c, inx_c;
    logic [2:0] flags_c, flags_p2;

    // Status: overflow, underflow (tiny result that is also inexact), inexact.
    always_comb begin
        ovf_c   = !zero_p1 && (efin_c >= EW'(EXP_INF));
        inx_c   = !zero_p1 && (g_c || sa_c || ovf_c);
        flags_c = {ovf_c, inx_c && (efin_c == '0), inx_c};
    end

    // Flags travel with the result in the output register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            flags_p2 <= '0;
        else if (load_p2 && vld_p1)
            flags_p2 <= flags_c;
    end

    assign Flags_o = flags_p2;
`endif

endmodule

// File: tb/tb_fma_post_normalizer.sv
// Bench for fma_post_normalizer: directed cases, backpressure, mid-flight reset
// and randomized beats scored against a value-level IEEE-754 rounding model.
module tb_fma_post_normalizer;

    logic               clk = 1'b0;
    logic               rst_i = 1'b1;
    logic               in_valid_i = 1'b0;
    logic               in_ready_o;
    logic               sign_in = 1'b0;
    logic signed [9:0]  exp_in = '0;
    logic [73:0]        mant_in = '0;
    logic               sticky_in = 1'b0;
    logic               out_valid_o;
    logic               out_ready_i = 1'b1;
    logic [31:0]        Result_o;
`ifdef POSTNORM_FLAGS_EN
    logic [2:0]         Flags_o;
`endif

    fma_post_normalizer dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .Sign_i     (sign_in),
        .Exp_i      (exp_in),
        .Mant_i     (mant_in),
        .Sticky_i   (sticky_in),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .Result_o   (Result_o)
`ifdef POSTNORM_FLAGS_EN
        ,
        .Flags_o    (Flags_o)
`endif
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [34:0] exp_q[$];
    int          cyc_q[$];
    bit          lat_q[$];
    bit          acc, obs_vld, rand_ready, cur_use, cur_lat;
    logic [31:0] obs_res;
    logic [34:0] cur_want;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_chk++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    // IEEE single RNE of (-1)^s * m * 2^(ex-127-47), plus sticky below m.
    // Returns {overflow, underflow, inexact, result[31:0]}.
    function automatic logic [34:0] ref_model(input logic s, input logic signed [9:0] ex,
                                              input logic [73:0] m, input logic st);
        logic [127:0] mm, kept;
        int           l, e, q, ebase;
        longint       word;
        logic         g, rest, up, ovf, inx, unf;
        if (m == '0) return '0;
        mm = 128'(m);
        l = 0;
        for (int i = 0; i < 74; i++) if (m[i]) l = i;
        e = int'(ex) + l - 47;
        if (e >= 1) begin q = l - 23;        ebase = e - 1; end
        else        begin q = 25 - int'(ex); ebase = 0;     end
        g = 1'b0; rest = st;
        if (q <= 0) kept = mm << (-q);
        else begin
            kept = mm >> q;
            if (q - 1 < 128) begin
                g    = mm[q-1];
                rest = st | ((mm & ((128'd1 << (q-1)) - 128'd1)) != '0);
            end else rest = st | (mm != '0);
        end
        up   = g & (rest | kept[0]);
        word = (longint'(ebase) << 23) + longint'(kept[31:0]) + longint'(up);
        ovf  = (word >= (longint'(255) << 23));
        if (ovf) word = longint'(32'h7F80_0000);
        inx  = g | rest | ovf;
        unf  = (word[30:23] == 8'd0) && inx;
        return {ovf, unf, inx, s, word[30:0]};
    endfunction

    // One clock: sample at the falling edge, score outputs, record accepted beats.
    task automatic tick();
        logic [34:0] e;
        int          c;
        bit          l;
        @(negedge clk);
        cyc++;
        obs_vld = out_valid_o;
        obs_res = Result_o;
        acc     = in_valid_i && in_ready_o;
        if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) check("out_without_beat", 64'(out_valid_o), 64'd0);
            else begin
                e = exp_q.pop_front(); c = cyc_q.pop_front(); l = lat_q.pop_front();
                check("result", 64'(Result_o), 64'(e[31:0]));
`ifdef POSTNORM_FLAGS_EN
                check("flags", 64'(Flags_o), 64'(e[34:32]));
`endif
                if (l) check("latency", 64'(cyc - c), 64'd3);
            end
        end
        if (acc) begin
            exp_q.push_back(cur_use ? cur_want : ref_model(sign_in, exp_in, mant_in, sticky_in));
            cyc_q.push_back(cyc);
            lat_q.push_back(cur_lat);
        end
        @(posedge clk); #1;
        if (rand_ready) out_ready_i = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic s, input logic signed [9:0] ex, input logic [73:0] m,
                        input logic st, input bit use_want, input logic [34:0] want, input bit lat);
        sign_in = s; exp_in = ex; mant_in = m; sticky_in = st;
        cur_use = use_want; cur_want = want; cur_lat = lat;
        in_valid_i = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (acc) break;
        end
        if (!acc) check("send_timeout", 64'(acc), 64'd1);
        in_valid_i = 1'b0;
        cur_use = 1'b0; cur_lat = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [73:0]       bp_m[6];
    logic signed [9:0] bp_e[6];
    logic              bp_s[6];
    logic [31:0]       held;
    bit                have_held;
    int                n_acc;
    logic [73:0]       rm;

    initial begin
        rand_ready = 1'b0; cur_use = 1'b0; cur_lat = 1'b0; cur_want = '0;
        // reset state
        repeat (2) @(posedge clk); #1;
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_result", 64'(Result_o), 64'd0);
`ifdef POSTNORM_FLAGS_EN
        check("rst_flags", 64'(Flags_o), 64'd0);
`endif
        rst_i = 1'b0;
        tick();
        check("ready_after_rst", 64'(in_ready_o), 64'd1);

        // directed values
        send(1'b0, 10'sd127, 74'd1 << 47, 1'b0, 1, {3'b000, 32'h3F80_0000}, 1);
        drain();
        send(1'b0, 10'sd127, 74'd1 << 48, 1'b0, 1, {3'b000, 32'h4000_0000}, 0);
        send(1'b1, 10'sd127, 74'd1 << 48, 1'b0, 1, {3'b000, 32'hC000_0000}, 0);
        send(1'b0, 10'sd127, (74'd1 << 47) | (74'd1 << 23), 1'b0, 1, {3'b001, 32'h3F80_0000}, 0);
        send(1'b0, 10'sd127, (74'd1 << 47) | (74'd1 << 23), 1'b1, 1, {3'b001, 32'h3F80_0001}, 0);
        send(1'b0, 10'sd254, 74'd1 << 48, 1'b0, 1, {3'b101, 32'h7F80_0000}, 0);
        send(1'b0, 10'h3F6, 74'd1 << 47, 1'b0, 1, {3'b000, 32'h0000_1000}, 0);
        send(1'b0, 10'sd127, (74'd1 << 48) - 74'd1, 1'b0, 1, {3'b001, 32'h4000_0000}, 0);
        send(1'b0, 10'sd0, (74'd1 << 48) - 74'd1, 1'b0, 1, {3'b001, 32'h0080_0000}, 0);
        send(1'b1, 10'sd5, 74'd0, 1'b0, 1, {3'b000, 32'h0000_0000}, 0);
        drain();

        // backpressure: consumer stalled for 8 cycles while 6 beats are offered
        for (int i = 0; i < 6; i++) begin
            bp_s[i] = 1'($urandom_range(0, 1));
            bp_e[i] = 10'($urandom_range(100, 150));
            bp_m[i] = 74'({$urandom, $urandom, $urandom}) >> $urandom_range(0, 40);
            if (bp_m[i] == '0) bp_m[i] = 74'd1 << 47;
        end
        out_ready_i = 1'b0; n_acc = 0; have_held = 1'b0;
        sign_in = bp_s[0]; exp_in = bp_e[0]; mant_in = bp_m[0]; sticky_in = 1'b0;
        in_valid_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (acc) begin
                n_acc++;
                if (n_acc < 6) begin
                    sign_in = bp_s[n_acc]; exp_in = bp_e[n_acc]; mant_in = bp_m[n_acc];
                end
            end
            if (obs_vld) begin
                if (!have_held) begin held = obs_res; have_held = 1'b1; end
                else check("stall_hold", 64'(obs_res), 64'(held));
            end
        end
        check("stall_accepted", 64'(n_acc), 64'd3);
        check("stall_in_ready", 64'(in_ready_o), 64'd0);
        check("stall_out_valid", 64'(out_valid_o), 64'd1);
        out_ready_i = 1'b1;
        for (int k = 0; k < 40 && n_acc < 6; k++) begin
            tick();
            if (acc) begin
                n_acc++;
                if (n_acc < 6) begin
                    sign_in = bp_s[n_acc]; exp_in = bp_e[n_acc]; mant_in = bp_m[n_acc];
                end
            end
        end
        in_valid_i = 1'b0;
        check("stall_all_sent", 64'(n_acc), 64'd6);
        drain();

        // reset with beats in flight
        out_ready_i = 1'b0;
        send(1'b0, 10'sd127, 74'd1 << 47, 1'b0, 1, {3'b000, 32'h3F80_0000}, 0);
        send(1'b0, 10'sd127, 74'd1 << 48, 1'b0, 1, {3'b000, 32'h4000_0000}, 0);
        tick();
        check("pre_rst_valid", 64'(out_valid_o), 64'd1);
        check("pre_rst_result", 64'(Result_o), 64'h3F80_0000);
        rst_i = 1'b1;
        #1;
        check("midrst_valid", 64'(out_valid_o), 64'd0);
        check("midrst_result", 64'(Result_o), 64'd0);
        exp_q.delete(); cyc_q.delete(); lat_q.delete();
        @(posedge clk); #1;
        rst_i = 1'b0; out_ready_i = 1'b1;
        tick();
        check("midrst_ready", 64'(in_ready_o), 64'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_quiet", 64'(obs_vld), 64'd0);
        end

        // randomized beats with random consumer stalls and input gaps
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rm = 74'({$urandom, $urandom, $urandom}) >> $urandom_range(0, 73);
            if ($urandom_range(0, 15) == 0) rm = '0;
            send(1'($urandom_range(0, 1)), 10'($urandom_range(0, 340) - 40), rm,
                 (rm == '0) ? 1'b0 : 1'($urandom_range(0, 1)), 0, '0, 0);
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_ready = 1'b0; out_ready_i = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fma_post_normalizer.md
Name: fma_post_normalizer

Overview:
- Back end of the FMA datapath: consumes the wide aligned-and-added sum and converts it to a packed IEEE-754 result.
- Three pipeline stages:
  - leading-one detect
  - normalize shift and exponent adjust
  - round-to-nearest-even and pack
- valid/ready handshake on both sides; sits between the mantissa adder and the result writeback.

Parameters:
- PARM_EXP, 8, exponent field width
- PARM_MANT, 23, stored mantissa width
- PARM_BIAS, 127, exponent bias

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  block can accept input this cycle
- Sign_i  in  1  sign of the sum magnitude
- Exp_i  in  PARM_EXP+2  signed two's-complement biased exponent; see Behaviour for bit weights
- Mant_i  in  3*PARM_MANT+5 (74)  unsigned sum magnitude
- Sticky_i  in  1  OR of all bits already dropped below Mant_i[0]
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- Result_o  out  PARM_EXP+PARM_MANT+1  packed IEEE-754 result

Behaviour:
- Reset (async, rst_i=1): all stage valid bits 0, out_valid_o=0, Result_o=0, all pipeline data regs 0. in_ready_o=1 one cycle after rst_i deasserts. A reset mid-operation discards all in-flight beats.
- Handshake: a transfer occurs when valid && ready on the same edge.
  - Each stage advances when its successor is empty or advancing.
  - in_ready_o = !s1_valid | s1_advance.
  - out_valid_o/Result_o are held stable while out_ready_i=0.
  - No beat is lost, duplicated or reordered.
- Latency: exactly 3 cycles from input handshake to out_valid_o when not stalled. Throughput: 1 per cycle.
- Value convention: bit index P=2*PARM_MANT+1 (47) of Mant_i has weight 2^(Exp_i-PARM_BIAS).
- S1 (leading-one detect):
  - Register L = leading-one index of Mant_i, plus a zero flag Z = (Mant_i==0).
  - Register Sign, Exp, Mant and Sticky.
- S2 (normalize):
  - E_r = Exp + (L-P), computed in PARM_EXP+3 signed bits.
  - If E_r>=1: shift left so the leading one lands at bit 73.
  - If E_r<=0 (subnormal): shift so the leading one lands at bit 73-(1-E_r); saturate right shift at 74. Set E_r=0.
  - Bits shifted out OR into sticky.
- S3 (round and pack):
  - Fraction = bits 72..72-PARM_MANT+1.
  - Guard bit = next bit below the fraction. sticky_all = OR(lower bits, sticky).
  - Round up if G & (sticky_all | lsb).
  - Mantissa carry-out increments the exponent; a subnormal carrying into the hidden bit becomes exponent 1.
- Overflow: final E_r >= 2^PARM_EXP-1 gives signed infinity (exp all ones, fraction 0).
- Zero: Z && !Sticky_i gives +0 (exact cancellation under RNE). Z && Sticky_i is a caller error; the output is undefined but the handshake is unaffected.
- No NaN/Inf inputs are handled here; special operands bypass this block.

Optional Feature:
- Macro: POSTNORM_FLAGS_EN.
- Defined:
  - Adds output Flags_o [2:0] = {overflow, underflow, inexact}, registered alongside Result_o and reset to 0.
  - underflow = result subnormal or zero and inexact.
  - inexact = G | sticky_all, or overflow.
- Undefined: port absent, and no flag logic is synthesized.

Test Plan:
- Exact 1.0: Sign_i=0, Exp_i=127, Mant_i=1<<47, Sticky_i=0 -> Result_o=0x3F800000, exactly 3 cycles after the handshake.
- Carry renormalize: Exp_i=127, Mant_i=1<<48 -> 0x40000000. Same with Sign_i=1 -> 0xC0000000.
- RNE tie: Exp_i=127, Mant_i=(1<<47)|(1<<23), Sticky_i=0 -> 0x3F800000. Same with Sticky_i=1 -> 0x3F800001 (inexact=1 with POSTNORM_FLAGS_EN).
- Overflow: Exp_i=254, Mant_i=1<<48 -> 0x7F800000 (overflow=1, inexact=1). Subnormal: Exp_i=-10 (10'h3F6), Mant_i=1<<47 -> 0x00001000.
- Backpressure: 6 back-to-back beats with out_ready_i=0 for 8 cycles -> in_ready_o falls after 3 accepted; Result_o stable throughout; all 6 results emerge in order once ready returns.
- Reset mid-flight: assert rst_i with 2 beats in flight -> out_valid_o=0 and Result_o=0 immediately, no stale output after release.
